uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/ktc32_uart_pkg.sv | 16 +
 rtl/uart_rx_fifo.sv | 62 ++++++
 rtl/uart_rx.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/ktc32_uart_pkg.sv
// Shared definitions for the UART receive path: default timing and buffer
// sizing, plus the receiver FSM state encoding.
package ktc32_uart_pkg;

    // 12 MHz clock / 115200 baud
    localparam int DEF_CLKS_PER_BIT = 104;
    localparam int DEF_FIFO_DEPTH   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO for received characters. A push that
// arrives while full is accepted only if the head is popped in the same
// cycle; otherwise it is dropped and drop_o pulses for that cycle.
module uart_rx_fifo
    import ktc32_uart_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       push_i,
    input  logic [7:0] wdata_i,
    input  logic       pop_i,
    output logic [7:0] rdata_o,
    output logic       full_o,
    output logic       empty_o,
    output logic       drop_o
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;
    logic [7:0]    mem_q [DEPTH];
    logic          do_pop;
    logic          do_push;

    // Occupancy decode and push/pop qualification.
    always_comb begin
        empty_o = (wr_ptr_q == rd_ptr_q);
        full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
        drop_o  = push_i && full_o && !pop_i;
        rdata_o = empty_o ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
    end

    // Storage array; contents are meaningless while empty, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

    // Read and write pointers, wrapping naturally modulo 2*DEPTH.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes rxd, centres sampling on the start bit,
// shifts in eight data bits LSB first, checks the stop bit and buffers good
// bytes in a small FWFT FIFO. Overrun and framing errors are sticky until
// clear_err; a new error event in the same cycle as clear_err wins.
module uart_rx
    import ktc32_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       rxd,
    input  logic       rd_en,
    input  logic       clear_err,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       overrun,
    output logic       frame_err,
    output rx_state_e  dbg_state_o
);

    localparam int                CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    logic [1:0]        sync_q;
    logic              rxd_s;
    rx_state_e         state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        idx_q;
    logic [7:0]        shift_q;
    logic              frame_err_q;
    logic              overrun_q;
    logic              stop_tick;
    logic              push;
    logic              fifo_drop;
    logic              fifo_full;
    logic              fifo_empty;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rxd};
        end
    end

    assign rxd_s = sync_q[1];

    // A good stop bit pushes in the same edge the FSM returns to IDLE.
    always_comb begin
        stop_tick = (state_q == ST_STOP) && (cnt_q == FULL_M1);
        push      = stop_tick && rxd_s;
    end

    // Receiver FSM with bit timing, bit index, shifter and framing flag.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= 3'd0;
            shift_q     <= 8'h00;
            frame_err_q <= 1'b0;
        end else begin
            if (clear_err) begin
                frame_err_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (!rxd_s) begin
                        state_q <= ST_START;
                        cnt_q   <= '0;
                    end
                end
                ST_START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_q <= '0;
                        idx_q <= 3'd0;
                        // Line back high at mid start bit is a glitch.
                        state_q <= rxd_s ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q          <= '0;
                        shift_q[idx_q] <= rxd_s;
                        idx_q          <= idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            state_q <= ST_STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (stop_tick) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                        if (!rxd_s) begin
                            frame_err_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Sticky overrun flag; a drop in the same cycle as clear_err wins.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            overrun_q <= 1'b0;
        end else if (fifo_drop) begin
            overrun_q <= 1'b1;
        end else if (clear_err) begin
            overrun_q <= 1'b0;
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .n_reset (n_reset),
        .push_i  (push),
        .wdata_i (shift_q),
        .pop_i   (rd_en),
        .rdata_o (rx_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .drop_o  (fifo_drop)
    );

    assign rx_valid    = !fifo_empty;
    assign overrun     = overrun_q;
    assign frame_err   = frame_err_q;
    assign dbg_state_o = state_q;

endmodule
